final_schematic: RTL and testbench

- Pricing core for a timed-rental kiosk. The operator selects a client class with ClientA or ClientB, then presses duration buttons (30 min, 1 h, 2 h).
- The block accumulates the booked time and outputs the amount due as a 6-bit value.
- It also drives a constant 7-digit seven-segment pattern showing the team's student number on the board display.
- Top-level glue between board switches/buttons and the display drivers.

---
 rtl/final_schematic.sv | 108 ++++++++++
 tb/tb_final_schematic.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/final_schematic.sv
// Pricing core for a timed-rental kiosk plus a constant seven-segment student-number pattern.
// Define SEG_ACTIVE_LOW_EN to invert StudentNumbers for common-anode displays.
module final_schematic #(
  parameter int unsigned RATE_A    = 1,
  parameter int unsigned RATE_B    = 2,
  parameter int unsigned MAX_UNITS = 16
) (
  input  logic        Clock,
  input  logic        ResetN,
  input  logic        ClientA,
  input  logic        ClientB,
  input  logic        Button30Min,
  input  logic        Button1Hour,
  input  logic        Button2Hours,
  output logic [5:0]  ValueToPay,
  output logic [48:0] StudentNumbers
);

  typedef enum logic [1:0] {ClsNone, ClsA, ClsB} cls_e;

  // Bit order of the synchronized vector: {ClientA, ClientB, 30min, 1h, 2h}.
  logic [4:0] sync1_q, sync2_q;
  logic [2:0] btn_prev_q;
  logic [4:0] units_q, units_d;
  cls_e       cls_q, cls_d;

  logic [2:0] btn_rise;
  logic [2:0] add_units;
  logic [5:0] sum_units;
  logic       sel_a, sel_b;
  logic [31:0] rate;
  logic [31:0] price;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      btn_prev_q <= '0;
      units_q    <= '0;
      cls_q      <= ClsNone;
    end else begin
      sync1_q    <= {ClientA, ClientB, Button30Min, Button1Hour, Button2Hours};
      sync2_q    <= sync1_q;
      btn_prev_q <= sync2_q[2:0];
      units_q    <= units_d;
      cls_q      <= cls_d;
    end
  end

  always_comb begin
    btn_rise  = sync2_q[2:0] & ~btn_prev_q;
    // Weights 1, 2, 4 land on distinct bits, so the sum is a plain bit reorder.
    add_units = {btn_rise[0], btn_rise[1], btn_rise[2]};
    sum_units = {1'b0, units_q} + {3'b000, add_units};
    sel_a     = sync2_q[4] & ~sync2_q[3];
    sel_b     = sync2_q[3] & ~sync2_q[4];

    cls_d   = ClsNone;
    units_d = '0;
    if (sel_a) begin
      cls_d = ClsA;
    end else if (sel_b) begin
      cls_d = ClsB;
    end

    if (cls_d == ClsNone) begin
      units_d = '0;
    end else if ((cls_q != ClsNone) && (cls_q != cls_d)) begin
      // Class change discards the previous booking, including edges of this cycle.
      units_d = '0;
    end else if (32'(sum_units) > MAX_UNITS) begin
      units_d = 5'(MAX_UNITS);
    end else begin
      units_d = sum_units[4:0];
    end
  end

  always_comb begin
    rate = '0;
    unique case (cls_q)
      ClsA:    rate = RATE_A;
      ClsB:    rate = RATE_B;
      default: rate = '0;
    endcase
    price = 32'(units_q) * rate;
    if (price > 32'd63) begin
      ValueToPay = 6'd63;
    end else begin
      ValueToPay = price[5:0];
    end
  end

  // Digits "2019123", gfedcba encoding, leftmost digit in the top bits.
  localparam logic [6:0] SegDig0 = 7'h3F;
  localparam logic [6:0] SegDig1 = 7'h06;
  localparam logic [6:0] SegDig2 = 7'h5B;
  localparam logic [6:0] SegDig3 = 7'h4F;
  localparam logic [6:0] SegDig9 = 7'h6F;
  localparam logic [48:0] SegPattern =
    {SegDig2, SegDig0, SegDig1, SegDig9, SegDig1, SegDig2, SegDig3};

`ifdef SEG_ACTIVE_LOW_EN
  assign StudentNumbers = ~SegPattern;
`else
  assign StudentNumbers = SegPattern;
`endif

endmodule

// File: tb/tb_final_schematic.sv
// Directed bench for final_schematic: input-history pricing model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_final_schematic;

  logic        Clock = 1'b0;
  logic        ResetN = 1'b0;
  logic        ClientA = 1'b0;
  logic        ClientB = 1'b0;
  logic        Button30Min = 1'b0;
  logic        Button1Hour = 1'b0;
  logic        Button2Hours = 1'b0;
  logic [5:0]  ValueToPay;
  logic [48:0] StudentNumbers;

  int n_vec = 0;
  int n_err = 0;

  final_schematic dut (
    .Clock(Clock),
    .ResetN(ResetN),
    .ClientA(ClientA),
    .ClientB(ClientB),
    .Button30Min(Button30Min),
    .Button1Hour(Button1Hour),
    .Button2Hours(Button2Hours),
    .ValueToPay(ValueToPay),
    .StudentNumbers(StudentNumbers)
  );

  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an input seen by the DUT two edges late; rising edges are h2 & ~h3.
  logic [4:0] h1, h2, h3;
  int m_units, m_cls;
  int cls_now, add_now;

  function automatic int client_of(input logic [4:0] v);
    if (v[4] && !v[3]) return 1;
    if (v[3] && !v[4]) return 2;
    return 0;
  endfunction

  function automatic int model_price(input int units, input int cls);
    int p;
    p = (cls == 1) ? units * 1 : (cls == 2) ? units * 2 : 0;
    return (p > 63) ? 63 : p;
  endfunction

  always @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      h1 <= '0;
      h2 <= '0;
      h3 <= '0;
      m_units <= 0;
      m_cls <= 0;
    end else begin
      cls_now = client_of(h2);
      add_now = ((h2[2] && !h3[2]) ? 1 : 0) + ((h2[1] && !h3[1]) ? 2 : 0)
              + ((h2[0] && !h3[0]) ? 4 : 0);
      if (cls_now == 0 || (m_cls != 0 && m_cls != cls_now)) m_units <= 0;
      else m_units <= (m_units + add_now > 16) ? 16 : m_units + add_now;
      m_cls <= cls_now;
      h1 <= {ClientA, ClientB, Button30Min, Button1Hour, Button2Hours};
      h2 <= h1;
      h3 <= h2;
    end
  end

  always @(negedge Clock) begin
    check("value_model", longint'(ValueToPay), longint'(model_price(m_units, m_cls)));
  end

  function automatic logic [48:0] expected_digits();
    logic [6:0] lut [10];
    int digits [7];
    logic [48:0] r;
    lut = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    digits = '{2, 0, 1, 9, 1, 2, 3};
    r = '0;
    for (int i = 0; i < 7; i++) r = {r[41:0], lut[digits[i]]};
`ifdef SEG_ACTIVE_LOW_EN
    r = ~r;
`endif
    return r;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // One-cycle pulse on button 0=30min, 1=1h, 2=2h, then n idle cycles.
  task automatic pulse(input int b, input int n);
    if (b == 0) Button30Min = 1'b1;
    else if (b == 1) Button1Hour = 1'b1;
    else Button2Hours = 1'b1;
    cycles(1);
    Button30Min = 1'b0;
    Button1Hour = 1'b0;
    Button2Hours = 1'b0;
    cycles(n);
  endtask

  initial begin
    cycles(3);
    check("reset_value", longint'(ValueToPay), 0);
    check("seg_pattern_reset", longint'(StudentNumbers), longint'(expected_digits()));
    ResetN = 1'b1;
    cycles(2);

    // Client selection alone never charges anything.
    ClientA = 1'b1;
    cycles(10);
    check("client_a_idle", longint'(ValueToPay), 0);
    ClientA = 1'b0;
    ClientB = 1'b1;
    cycles(10);
    check("client_b_idle", longint'(ValueToPay), 0);

    // Class A: 1h then 30min, with explicit latency check.
    ClientB = 1'b0;
    ClientA = 1'b1;
    cycles(4);
    Button1Hour = 1'b1;
    cycles(1);
    Button1Hour = 1'b0;
    check("lat_edge_n", longint'(ValueToPay), 0);
    cycles(1);
    check("lat_edge_n1", longint'(ValueToPay), 0);
    cycles(1);
    check("a_1h", longint'(ValueToPay), 2);
    pulse(0, 3);
    check("a_30m", longint'(ValueToPay), 3);
    Button1Hour = 1'b1;
    cycles(10);
    Button1Hour = 1'b0;
    cycles(4);
    check("a_hold_1h", longint'(ValueToPay), 5);

    // Switch to B clears; 2h pulses saturate at 16 units.
    ClientA = 1'b0;
    ClientB = 1'b1;
    cycles(4);
    check("switch_to_b", longint'(ValueToPay), 0);
    pulse(2, 3);
    check("b_2h_x1", longint'(ValueToPay), 8);
    pulse(2, 3);
    pulse(2, 3);
    check("b_2h_x3", longint'(ValueToPay), 24);
    pulse(2, 3);
    check("b_2h_x4", longint'(ValueToPay), 32);
    pulse(2, 3);
    check("b_2h_sat", longint'(ValueToPay), 32);
    pulse(2, 3);
    check("b_2h_sat2", longint'(ValueToPay), 32);

    // Back to A with 4 units, then B clears, then both invalid.
    ClientB = 1'b0;
    ClientA = 1'b1;
    cycles(4);
    check("switch_to_a", longint'(ValueToPay), 0);
    pulse(2, 3);
    check("a_4units", longint'(ValueToPay), 4);
    ClientA = 1'b0;
    ClientB = 1'b1;
    cycles(4);
    check("a_to_b_clear", longint'(ValueToPay), 0);
    ClientA = 1'b1;
    cycles(4);
    pulse(0, 2);
    pulse(1, 2);
    pulse(2, 3);
    check("both_ignored", longint'(ValueToPay), 0);
    ClientB = 1'b0;
    cycles(4);
    check("both_then_a", longint'(ValueToPay), 0);

    // Async reset mid-booking at 6 units.
    pulse(2, 2);
    pulse(1, 3);
    check("a_6units", longint'(ValueToPay), 6);
    @(posedge Clock);
    #2;
    ResetN = 1'b0;
    #1;
    check("async_reset", longint'(ValueToPay), 0);
    cycles(2);
    ResetN = 1'b1;
    cycles(4);
    check("after_reset_idle", longint'(ValueToPay), 0);
    pulse(0, 3);
    check("after_reset_30m", longint'(ValueToPay), 1);
    check("seg_pattern_end", longint'(StudentNumbers), longint'(expected_digits()));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
